// File: rtl/riscv_pipe_ctrl.sv
// riscv_pipe_ctrl: pipelined control unit for the RV32I 5-stage core.
// Decodes in ID, carries the control bundle through ID/EX, EX/MEM and MEM/WB,
// resolves conditional branches in EX and raises stall/flush for hazards.
// Optional feature: define RISCV_PIPE_CTRL_FWD_EN to add the fwd_a/fwd_b
// forwarding selects and limit hazard stalls to load-use only.

module riscv_pipe_ctrl #(
  parameter int REG_AW       = 5,
  parameter int ALUOP_W      = 2,
  parameter int ILLEGAL_TRAP = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [6:0]         id_opcode,
  input  logic [2:0]         id_funct3,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic [REG_AW-1:0]  id_rs1,
  input  logic [REG_AW-1:0]  id_rs2,
  input  logic               ex_zero,
  input  logic               ex_sign,
  input  logic               ex_ltu,
  output logic               stall,
  output logic               flush,
  output logic               pc_src,
  output logic [5:0]         ex_ctrl,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_illegal,
  output logic [3:0]         mem_ctrl,
  output logic [REG_AW-1:0]  mem_rd,
  output logic [1:0]         wb_ctrl,
  output logic [REG_AW-1:0]  wb_rd
`ifdef RISCV_PIPE_CTRL_FWD_EN
  ,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b
`endif
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic       TRAP_EN    = (ILLEGAL_TRAP != 0);

  // Decoded ID control
  logic               d_legal;
  logic               d_rs2_used;
  logic               d_reg_write;
  logic               d_alu_src;
  logic [1:0]         d_imm_src;
  logic               d_mem_read;
  logic               d_mem_write;
  logic               d_result_src;
  logic               d_branch;
  logic [ALUOP_W-1:0] d_alu_op;
  logic               d_illegal;

  // ID/EX register contents (ex_alu_op and ex_illegal are ports)
  logic               ex_valid;
  logic               ex_alu_src;
  logic [1:0]         ex_imm_src;
  logic               ex_branch;
  logic               ex_mem_read;
  logic               ex_mem_write;
  logic               ex_result_src;
  logic               ex_reg_write;
  logic [2:0]         ex_funct3;
  logic [REG_AW-1:0]  ex_rd;
`ifdef RISCV_PIPE_CTRL_FWD_EN
  logic [REG_AW-1:0]  ex_rs1;
  logic [REG_AW-1:0]  ex_rs2;
`endif

  logic br_cond;
  logic ex_hit;
  logic load_use;
  logic hazard;
  logic id_take;

  // Opcode decode of the instruction sitting in ID
  always_comb begin
    d_legal      = 1'b0;
    d_rs2_used   = 1'b0;
    d_reg_write  = 1'b0;
    d_alu_src    = 1'b0;
    d_imm_src    = 2'b00;
    d_mem_read   = 1'b0;
    d_mem_write  = 1'b0;
    d_result_src = 1'b0;
    d_branch     = 1'b0;
    d_alu_op     = '0;
    case (id_opcode)
      OPC_LOAD: begin
        d_legal      = 1'b1;
        d_reg_write  = 1'b1;
        d_alu_src    = 1'b1;
        d_imm_src    = 2'b00;
        d_mem_read   = 1'b1;
        d_result_src = 1'b1;
        d_alu_op     = ALUOP_W'(2'b00);
      end
      OPC_STORE: begin
        d_legal     = 1'b1;
        d_rs2_used  = 1'b1;
        d_alu_src   = 1'b1;
        d_imm_src   = 2'b01;
        d_mem_write = 1'b1;
        d_alu_op    = ALUOP_W'(2'b00);
      end
      OPC_RTYPE: begin
        d_legal     = 1'b1;
        d_rs2_used  = 1'b1;
        d_reg_write = 1'b1;
        d_alu_op    = ALUOP_W'(2'b10);
      end
      OPC_ITYPE: begin
        d_legal     = 1'b1;
        d_reg_write = 1'b1;
        d_alu_src   = 1'b1;
        d_imm_src   = 2'b00;
        d_alu_op    = ALUOP_W'(2'b10);
      end
      OPC_BRANCH: begin
        d_legal    = 1'b1;
        d_rs2_used = 1'b1;
        d_branch   = 1'b1;
        d_imm_src  = 2'b10;
        d_alu_op   = ALUOP_W'(2'b01);
      end
      default: d_legal = 1'b0;
    endcase
  end

  assign d_illegal = ~d_legal & TRAP_EN;

  // Branch condition from the funct3 held in ID/EX and the ALU flags
  always_comb begin
    br_cond = 1'b0;
    case (ex_funct3)
      3'b000:  br_cond = ex_zero;
      3'b001:  br_cond = ~ex_zero;
      3'b100:  br_cond = ex_sign;
      3'b101:  br_cond = ~ex_sign;
      3'b110:  br_cond = ex_ltu;
      3'b111:  br_cond = ~ex_ltu;
      default: br_cond = 1'b0;
    endcase
  end

  assign pc_src = ex_valid & ex_branch & br_cond;
  assign flush  = pc_src;

  // ex_rd is already zero unless the EX instruction writes a register
  assign ex_hit   = id_valid && (ex_rd != '0) &&
                    ((d_legal && (ex_rd == id_rs1)) || (d_rs2_used && (ex_rd == id_rs2)));
  assign load_use = ex_valid & ex_mem_read & ex_hit;

`ifdef RISCV_PIPE_CTRL_FWD_EN
  assign hazard = load_use;
`else
  logic mem_hit;
  // mem_rd is zero unless the MEM instruction writes a register
  assign mem_hit = id_valid && (mem_rd != '0) &&
                   ((d_legal && (mem_rd == id_rs1)) || (d_rs2_used && (mem_rd == id_rs2)));
  assign hazard  = load_use | (ex_valid & ex_reg_write & ex_hit) | mem_hit;
`endif

  assign stall   = hazard & ~pc_src;
  assign id_take = id_valid & ~pc_src & ~stall;

  // ID/EX register: takes the decoded bundle or a bubble on flush/stall/empty ID
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_imm_src    <= 2'b00;
      ex_branch     <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_result_src <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_alu_op     <= '0;
      ex_funct3     <= 3'b000;
      ex_rd         <= '0;
      ex_illegal    <= 1'b0;
`ifdef RISCV_PIPE_CTRL_FWD_EN
      ex_rs1        <= '0;
      ex_rs2        <= '0;
`endif
    end else begin
      ex_valid      <= id_take & d_legal;
      ex_alu_src    <= id_take & d_alu_src;
      ex_imm_src    <= id_take ? d_imm_src : 2'b00;
      ex_branch     <= id_take & d_branch;
      ex_mem_read   <= id_take & d_mem_read;
      ex_mem_write  <= id_take & d_mem_write;
      ex_result_src <= id_take & d_result_src;
      ex_reg_write  <= id_take & d_reg_write;
      ex_alu_op     <= id_take ? d_alu_op : '0;
      ex_funct3     <= id_take ? id_funct3 : 3'b000;
      ex_rd         <= (id_take && d_reg_write) ? id_rd : '0;
      ex_illegal    <= id_take & d_illegal;
`ifdef RISCV_PIPE_CTRL_FWD_EN
      ex_rs1        <= (id_take && d_legal) ? id_rs1 : '0;
      ex_rs2        <= (id_take && d_rs2_used) ? id_rs2 : '0;
`endif
    end
  end

  assign ex_ctrl = {ex_alu_src, ex_imm_src, ex_branch, ex_mem_read, ex_valid};

  // EX/MEM and MEM/WB registers: always advance, never stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ctrl <= 4'b0000;
      mem_rd   <= '0;
      wb_ctrl  <= 2'b00;
      wb_rd    <= '0;
    end else begin
      mem_ctrl <= {ex_mem_write, ex_mem_read, ex_result_src, ex_reg_write};
      mem_rd   <= ex_reg_write ? ex_rd : '0;
      wb_ctrl  <= mem_ctrl[1:0];
      wb_rd    <= mem_ctrl[0] ? mem_rd : '0;
    end
  end

`ifdef RISCV_PIPE_CTRL_FWD_EN
  // Forwarding selects for the EX operands; the younger EX/MEM result wins
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (mem_ctrl[0] && (mem_rd != '0) && (mem_rd == ex_rs1)) begin
      fwd_a = 2'b10;
    end else if (wb_ctrl[0] && (wb_rd != '0) && (wb_rd == ex_rs1)) begin
      fwd_a = 2'b01;
    end
    if (mem_ctrl[0] && (mem_rd != '0) && (mem_rd == ex_rs2)) begin
      fwd_b = 2'b10;
    end else if (wb_ctrl[0] && (wb_rd != '0) && (wb_rd == ex_rs2)) begin
      fwd_b = 2'b01;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_pipe_ctrl.sv
// tb_riscv_pipe_ctrl: self-checking bench for riscv_pipe_ctrl.
// Tracks whole instructions per pipeline slot and derives every expected
// output from the instruction class; a second instance checks ILLEGAL_TRAP=0.
// Honours RISCV_PIPE_CTRL_FWD_EN the same way the design does.

module tb_riscv_pipe_ctrl;

  localparam logic [6:0] LW = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011;
  localparam logic [6:0] RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011;

  typedef enum logic [2:0] {K_NONE, K_LOAD, K_STORE, K_RTYPE, K_ITYPE, K_BRANCH, K_ILL} kind_t;
  typedef struct packed {
    kind_t      kind;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] f3;
  } slot_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       id_valid, ex_zero, ex_sign, ex_ltu;
  logic [6:0] id_opcode;
  logic [2:0] id_funct3;
  logic [4:0] id_rd, id_rs1, id_rs2;

  logic       stall, flush, pc_src, ex_illegal;
  logic [5:0] ex_ctrl;
  logic [1:0] ex_alu_op, wb_ctrl;
  logic [3:0] mem_ctrl;
  logic [4:0] mem_rd, wb_rd;

  logic       n_stall, n_flush, n_pc_src, n_ex_illegal;
  logic [5:0] n_ex_ctrl;
  logic [1:0] n_ex_alu_op, n_wb_ctrl;
  logic [3:0] n_mem_ctrl;
  logic [4:0] n_mem_rd, n_wb_rd;

`ifdef RISCV_PIPE_CTRL_FWD_EN
  logic [1:0] fwd_a, fwd_b, n_fwd_a, n_fwd_b;
`endif

  int   checks = 0;
  int   errors = 0;
  logic check_en = 1'b0;

  slot_t ex_s  = '0;
  slot_t mem_s = '0;
  slot_t wb_s  = '0;
  logic  m_taken, m_stall;

  logic [6:0] ops [0:6];
  logic [6:0] br_tab [0:8];

  always #5 clk = ~clk;

  riscv_pipe_ctrl #(.REG_AW(5), .ALUOP_W(2), .ILLEGAL_TRAP(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct3(id_funct3), .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_zero(ex_zero), .ex_sign(ex_sign), .ex_ltu(ex_ltu),
    .stall(stall), .flush(flush), .pc_src(pc_src), .ex_ctrl(ex_ctrl),
    .ex_alu_op(ex_alu_op), .ex_illegal(ex_illegal), .mem_ctrl(mem_ctrl),
    .mem_rd(mem_rd), .wb_ctrl(wb_ctrl), .wb_rd(wb_rd)
`ifdef RISCV_PIPE_CTRL_FWD_EN
    , .fwd_a(fwd_a), .fwd_b(fwd_b)
`endif
  );

  riscv_pipe_ctrl #(.REG_AW(5), .ALUOP_W(2), .ILLEGAL_TRAP(0)) u_notrap (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct3(id_funct3), .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_zero(ex_zero), .ex_sign(ex_sign), .ex_ltu(ex_ltu),
    .stall(n_stall), .flush(n_flush), .pc_src(n_pc_src), .ex_ctrl(n_ex_ctrl),
    .ex_alu_op(n_ex_alu_op), .ex_illegal(n_ex_illegal), .mem_ctrl(n_mem_ctrl),
    .mem_rd(n_mem_rd), .wb_ctrl(n_wb_ctrl), .wb_rd(n_wb_rd)
`ifdef RISCV_PIPE_CTRL_FWD_EN
    , .fwd_a(n_fwd_a), .fwd_b(n_fwd_b)
`endif
  );

  // ---------------- reference model helpers ----------------
  function automatic kind_t classify(input logic [6:0] op);
    case (op)
      LW:      return K_LOAD;
      SW:      return K_STORE;
      RT:      return K_RTYPE;
      IT:      return K_ITYPE;
      BR:      return K_BRANCH;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic writes(input kind_t k);
    return (k == K_LOAD) || (k == K_RTYPE) || (k == K_ITYPE);
  endfunction

  function automatic logic legal(input kind_t k);
    return (k != K_NONE) && (k != K_ILL);
  endfunction

  function automatic logic uses_rs2(input kind_t k);
    return (k == K_RTYPE) || (k == K_STORE) || (k == K_BRANCH);
  endfunction

  // {alu_src, imm_src[1:0], branch, mem_read, valid}
  function automatic logic [5:0] exp_ex_ctrl(input kind_t k);
    case (k)
      K_LOAD:   return 6'b100011;
      K_STORE:  return 6'b101001;
      K_RTYPE:  return 6'b000001;
      K_ITYPE:  return 6'b100001;
      K_BRANCH: return 6'b010101;
      default:  return 6'b000000;
    endcase
  endfunction

  function automatic logic [1:0] exp_alu_op(input kind_t k);
    if (k == K_RTYPE || k == K_ITYPE) return 2'b10;
    if (k == K_BRANCH) return 2'b01;
    return 2'b00;
  endfunction

  // {mem_write, mem_read, result_src, reg_write}
  function automatic logic [3:0] exp_mem_ctrl(input kind_t k);
    return {k == K_STORE, k == K_LOAD, k == K_LOAD, writes(k)};
  endfunction

  function automatic logic [4:0] exp_rd(input slot_t s);
    return writes(s.kind) ? s.rd : 5'd0;
  endfunction

  function automatic logic exp_taken(input slot_t e, input logic z, input logic s, input logic l);
    if (e.kind != K_BRANCH) return 1'b0;
    case (e.f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return s;
      3'b101:  return !s;
      3'b110:  return l;
      3'b111:  return !l;
      default: return 1'b0;
    endcase
  endfunction

  // Does an ID instruction of class k read register r (r nonzero)?
  function automatic logic reads(input kind_t k, input logic [4:0] r,
                                 input logic [4:0] rs1, input logic [4:0] rs2);
    if (r == 5'd0 || !legal(k)) return 1'b0;
    return (r == rs1) || (uses_rs2(k) && r == rs2);
  endfunction

  function automatic logic exp_stall(input slot_t e, input slot_t m, input logic v,
                                     input logic [6:0] op, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic taken);
    kind_t k;
    k = classify(op);
    if (taken || !v) return 1'b0;
    if (e.kind == K_LOAD && reads(k, e.rd, rs1, rs2)) return 1'b1;
`ifndef RISCV_PIPE_CTRL_FWD_EN
    if (writes(e.kind) && reads(k, e.rd, rs1, rs2)) return 1'b1;
    if (writes(m.kind) && reads(k, m.rd, rs1, rs2)) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [1:0] exp_fwd(input slot_t e, input slot_t m, input slot_t w,
                                         input logic second);
    logic [4:0] src;
    if (second) begin
      if (!uses_rs2(e.kind)) return 2'b00;
      src = e.rs2;
    end else begin
      if (!legal(e.kind)) return 2'b00;
      src = e.rs1;
    end
    if (src == 5'd0) return 2'b00;
    if (writes(m.kind) && m.rd == src) return 2'b10;
    if (writes(w.kind) && w.rd == src) return 2'b01;
    return 2'b00;
  endfunction

  assign m_taken = exp_taken(ex_s, ex_zero, ex_sign, ex_ltu);
  assign m_stall = exp_stall(ex_s, mem_s, id_valid, id_opcode, id_rs1, id_rs2, m_taken);

  // Model pipeline: instructions move one slot per clock, ID enters EX unless killed
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_s  <= '0;
      mem_s <= '0;
      wb_s  <= '0;
    end else begin
      wb_s  <= mem_s;
      mem_s <= ex_s;
      if (id_valid && !m_taken && !m_stall)
        ex_s <= '{kind: classify(id_opcode), rd: id_rd, rs1: id_rs1, rs2: id_rs2, f3: id_funct3};
      else
        ex_s <= '0;
    end
  end

  // ---------------- bench tasks ----------------
  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [6:0] op, input logic [2:0] f3,
                               input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic z, input logic s, input logic l);
    id_valid  = v;
    id_opcode = op;
    id_funct3 = f3;
    id_rd     = rd;
    id_rs1    = rs1;
    id_rs2    = rs2;
    ex_zero   = z;
    ex_sign   = s;
    ex_ltu    = l;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (4) tick();
  endtask

  task automatic resetChecks();
    checkOutput("rst_ex_ctrl", 8'(ex_ctrl), 8'h00);
    checkOutput("rst_ex_alu_op", 8'(ex_alu_op), 8'h00);
    checkOutput("rst_ex_illegal", 8'(ex_illegal), 8'h00);
    checkOutput("rst_mem_ctrl", 8'(mem_ctrl), 8'h00);
    checkOutput("rst_mem_rd", 8'(mem_rd), 8'h00);
    checkOutput("rst_wb_ctrl", 8'(wb_ctrl), 8'h00);
    checkOutput("rst_wb_rd", 8'(wb_rd), 8'h00);
    checkOutput("rst_stall", 8'(stall), 8'h00);
    checkOutput("rst_flush", 8'(flush), 8'h00);
    checkOutput("rst_pc_src", 8'(pc_src), 8'h00);
  endtask

  task automatic compareAll();
    checkOutput("ex_ctrl", 8'(ex_ctrl), 8'(exp_ex_ctrl(ex_s.kind)));
    checkOutput("ex_alu_op", 8'(ex_alu_op), 8'(exp_alu_op(ex_s.kind)));
    checkOutput("ex_illegal", 8'(ex_illegal), 8'(ex_s.kind == K_ILL));
    checkOutput("notrap_ex_illegal", 8'(n_ex_illegal), 8'h00);
    checkOutput("notrap_ex_ctrl", 8'(n_ex_ctrl), 8'(exp_ex_ctrl(ex_s.kind)));
    checkOutput("pc_src", 8'(pc_src), 8'(m_taken));
    checkOutput("flush", 8'(flush), 8'(m_taken));
    checkOutput("stall", 8'(stall), 8'(m_stall));
    checkOutput("notrap_stall", 8'(n_stall), 8'(m_stall));
    checkOutput("mem_ctrl", 8'(mem_ctrl), 8'(exp_mem_ctrl(mem_s.kind)));
    checkOutput("mem_rd", 8'(mem_rd), 8'(exp_rd(mem_s)));
    checkOutput("wb_ctrl", 8'(wb_ctrl), 8'(exp_mem_ctrl(wb_s.kind) & 4'b0011));
    checkOutput("wb_rd", 8'(wb_rd), 8'(exp_rd(wb_s)));
`ifdef RISCV_PIPE_CTRL_FWD_EN
    checkOutput("fwd_a", 8'(fwd_a), 8'(exp_fwd(ex_s, mem_s, wb_s, 1'b0)));
    checkOutput("fwd_b", 8'(fwd_b), 8'(exp_fwd(ex_s, mem_s, wb_s, 1'b1)));
`endif
  endtask

  // ---------------- stimulus and comparison ----------------
  initial begin
    logic [6:0] ent;
    ops    = '{LW, SW, RT, IT, BR, 7'b1111111, 7'b0110111};
    // {funct3, zero, sign, ltu, taken}
    br_tab = '{7'b000_100_1, 7'b000_011_0, 7'b001_000_1, 7'b100_010_1, 7'b101_010_0,
               7'b110_001_1, 7'b111_001_0, 7'b010_111_0, 7'b011_111_0};
    idle();
    fork
      begin : compare_proc
        forever begin
          @(negedge clk);
          if (check_en) compareAll();
        end
      end
      begin : stim_proc
        #2 rst_n = 1'b0;
        check_en = 1'b1;
        @(negedge clk);
        resetChecks();
        repeat (2) tick();
        tick();
        rst_n = 1'b1;

        // Load-use: lw x5 ; add x6,x5,x1 (held in ID while stalled)
        applyStimulus(1'b1, LW, 3'b010, 5'd5, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, RT, 3'b000, 5'd6, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("lu_stall", 8'(stall), 8'h01);
        checkOutput("lu_ex_load", 8'(ex_ctrl), 8'h23);
        tick();
        @(negedge clk);
        checkOutput("lu_bubble", 8'(ex_ctrl), 8'h00);
        checkOutput("lu_mem_load", 8'(mem_ctrl), 8'h07);
        checkOutput("lu_mem_rd", 8'(mem_rd), 8'h05);
`ifdef RISCV_PIPE_CTRL_FWD_EN
        checkOutput("lu_stall_once", 8'(stall), 8'h00);
        tick();
`else
        checkOutput("lu_stall_mem", 8'(stall), 8'h01);
        tick();
        @(negedge clk);
        checkOutput("lu_stall_done", 8'(stall), 8'h00);
        tick();
`endif
        idle();
        @(negedge clk);
        checkOutput("lu_add_ex", 8'(ex_ctrl), 8'h01);
        checkOutput("lu_add_aluop", 8'(ex_alu_op), 8'h02);
        drain();

        // Load to x0 never stalls
        applyStimulus(1'b1, LW, 3'b010, 5'd0, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, RT, 3'b000, 5'd6, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("x0_no_stall", 8'(stall), 8'h00);
        tick();
        drain();

        // Branch conditions table
        for (int i = 0; i < 9; i++) begin
          ent = br_tab[i];
          applyStimulus(1'b1, BR, ent[6:4], 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
          tick();
          applyStimulus(1'b1, RT, 3'b000, 5'd7, 5'd1, 5'd2, ent[3], ent[2], ent[1]);
          @(negedge clk);
          checkOutput("br_ex_ctrl", 8'(ex_ctrl), 8'h15);
          checkOutput("br_aluop", 8'(ex_alu_op), 8'h01);
          checkOutput("br_pc_src", 8'(pc_src), 8'(ent[0]));
          checkOutput("br_flush", 8'(flush), 8'(ent[0]));
          tick();
          idle();
          @(negedge clk);
          checkOutput("br_next_ex", 8'(ex_ctrl), ent[0] ? 8'h00 : 8'h01);
          tick();
        end
        drain();

        // Taken branch in EX while ID holds an instruction depending on a load
        applyStimulus(1'b1, LW, 3'b010, 5'd5, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, BR, 3'b000, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, RT, 3'b000, 5'd6, 5'd5, 5'd1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("sf_flush", 8'(flush), 8'h01);
        checkOutput("sf_stall", 8'(stall), 8'h00);
        tick();
        idle();
        @(negedge clk);
        checkOutput("sf_bubble", 8'(ex_ctrl), 8'h00);
        drain();

        // Illegal opcode
        applyStimulus(1'b1, 7'b1111111, 3'b000, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        @(negedge clk);
        checkOutput("ill_trap", 8'(ex_illegal), 8'h01);
        checkOutput("ill_notrap", 8'(n_ex_illegal), 8'h00);
        checkOutput("ill_ex_ctrl", 8'(ex_ctrl), 8'h00);
        tick();
        @(negedge clk);
        checkOutput("ill_clear", 8'(ex_illegal), 8'h00);
        checkOutput("ill_no_write", 8'(mem_ctrl), 8'h00);
        drain();

        // Back-to-back RAW: add x3 ; sub x4,x3,x3
        applyStimulus(1'b1, RT, 3'b000, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, RT, 3'b000, 5'd4, 5'd3, 5'd3, 1'b0, 1'b0, 1'b0);
`ifdef RISCV_PIPE_CTRL_FWD_EN
        @(negedge clk);
        checkOutput("fwd_no_stall", 8'(stall), 8'h00);
        tick();
        idle();
        @(negedge clk);
        checkOutput("fwd_a_exmem", 8'(fwd_a), 8'h02);
        checkOutput("fwd_b_exmem", 8'(fwd_b), 8'h02);
        drain();
        applyStimulus(1'b1, RT, 3'b000, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        applyStimulus(1'b1, RT, 3'b000, 5'd4, 5'd3, 5'd3, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        @(negedge clk);
        checkOutput("fwd_a_memwb", 8'(fwd_a), 8'h01);
        checkOutput("fwd_b_memwb", 8'(fwd_b), 8'h01);
`else
        @(negedge clk);
        checkOutput("raw_stall1", 8'(stall), 8'h01);
        tick();
        @(negedge clk);
        checkOutput("raw_stall2", 8'(stall), 8'h01);
        tick();
        @(negedge clk);
        checkOutput("raw_done", 8'(stall), 8'h00);
        tick();
`endif
        drain();

        // Reset in the middle of traffic
        applyStimulus(1'b1, RT, 3'b000, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, LW, 3'b010, 5'd9, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, RT, 3'b000, 5'd10, 5'd9, 5'd3, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (3) begin
          @(negedge clk);
          resetChecks();
          tick();
        end
        rst_n = 1'b1;
        applyStimulus(1'b1, RT, 3'b000, 5'd8, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        repeat (2) tick();
        @(negedge clk);
        checkOutput("post_rst_wb_ctrl", 8'(wb_ctrl), 8'h01);
        checkOutput("post_rst_wb_rd", 8'(wb_rd), 8'h08);
        tick();

        // Randomized traffic on a small register set to provoke hazards
        for (int i = 0; i < 3000; i++) begin
          rst_n = ($urandom_range(0, 399) != 0);
          applyStimulus(1'($urandom_range(0, 7) != 0), ops[$urandom_range(0, 6)],
                        3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)),
                        5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)));
          tick();
        end
        rst_n = 1'b1;
        drain();
      end
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
